fdc_sd_arbiter: RTL and testbench
=================================

Name: fdc_sd_arbiter

Overview:
- Sits directly downstream of the four-drive floppy controller. Collects the per-drive SD block requests (sd_rd/sd_wr/sd_lba[4]) and serialises them onto one host SD block channel.
- Steers host ack and buffer-read data back to the requesting drive.
- Lets the CoCo FDC run on a single MiSTer virtual-disk port; host_unit identifies the image.

Parameters:
- NUM_DRIVES, 4, number of requesting drive channels (2..4).
- TIMEOUT_CYCLES, 33554432, cycles without host_ack before abort (used only with FDC_SD_ARB_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESET_N  in  1  reset, asynchronous, active-low.
- drv_lba  in  32 x NUM_DRIVES  per-drive block address.
- drv_rd  in  NUM_DRIVES  per-drive read request, level, held until its ack.
- drv_wr  in  NUM_DRIVES  per-drive write request, level, held until its ack.
- drv_ack  out  NUM_DRIVES  per-drive ack; only the granted bit can be 1.
- drv_buff_din  in  8 x NUM_DRIVES  per-drive write-buffer read data.
- host_lba  out  32  latched LBA of the granted request.
- host_unit  out  2  granted drive index.
- host_rd  out  1  host read request.
- host_wr  out  1  host write request.
- host_ack  in  1  host ack, high for the whole transfer.
- host_buff_din  out  8  = drv_buff_din[host_unit], combinational (zero added latency).
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky abort flag; tied 0 when the macro is absent.

Behaviour:
- Reset values:
  - Outputs host_rd, host_wr, drv_ack, busy, timeout_err = 0; host_lba = 0; host_unit = 0.
  - Internal: last_grant = NUM_DRIVES-1; state = IDLE.
- Request vector: req[i] = drv_rd[i] | drv_wr[i].
- Arbitration: round-robin, search starts at last_grant+1 and wraps modulo NUM_DRIVES.
- A drive raising both rd and wr is treated as a write (flush first); rd stays pending.
- States:
  - IDLE: if any req, pick winner. On the next edge latch host_unit, host_lba, dir; assert host_rd or host_wr; update last_grant; go REQ. Otherwise stay.
  - REQ: hold host_rd/host_wr and host_lba stable. On host_ack=1, drop host_rd/host_wr the same edge; go XFER.
  - XFER: drv_ack[host_unit] = host_ack (combinational, gated by state in REQ/XFER and by host_unit). On host_ack=0, go REL.
  - REL: one-cycle gap so the drive can deassert its level request; then IDLE. A request still high in IDLE after REL is re-arbitrated as new.
- Latency:
  - Request to host_rd/host_wr: 2 edges (sample, then latch and assert).
  - Back-to-back transfers: minimum 2 idle cycles between host_ack falling and the next host_rd/host_wr.
- Committed grant: once REQ is entered, host_rd/host_wr stay asserted until host_ack, even if the drive drops its request. The ack is still routed, and the drive ignores it.
- host_ack high while in IDLE (spurious): ignored; no drv_ack asserted.
- drv_lba changes after grant: ignored (latched copy used).
- Reset mid-transfer: immediate return to reset values. The host sees its request vanish, and drives re-request after reset.
- host_buff_din: selected by latched host_unit, so it is valid throughout XFER.
- Unused drive indices (>= NUM_DRIVES): never granted.

Optional Feature:
- Macro FDC_SD_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and XFER and clears on state entry.
  - Reaching TIMEOUT_CYCLES-1 forces host_rd/host_wr = 0, sets timeout_err (sticky until reset) and goes REL. No drv_ack is generated.
- Undefined: no counter; REQ/XFER wait indefinitely; timeout_err tied 0.

Decomposition:
- Package fdc_sd_pkg:
  - state enum arb_state_t {IDLE, REQ, XFER, REL};
  - constant MAX_DRIVES=4;
  - typedef drive_idx_t logic[1:0].
- Sub-module fdc_rr_pick: combinational round-robin picker. Inputs req vector and last_grant; outputs valid and winner index.

Test Plan:
- Single read: drv_rd[1]=1, drv_lba[1]=0x123.
  - 2 edges later: host_rd=1, host_unit=1, host_lba=0x123.
  - Host holds ack 512 cycles: drv_ack=4'b0010 throughout.
  - host_rd drops on the ack edge; busy falls 2 cycles after ack falls.
- Contention: drv_rd=4'b1111 held, each drive dropping its request on its own ack. Grant order is 0,1,2,3; a re-raised drv_rd[0] is served after 3.
- Same-drive rd+wr: drv_rd[2]=drv_wr[2]=1.
  - First transfer: host_wr=1.
  - After REL, with rd still high: host_rd=1, unit 2.
- Buffer steering: drv_buff_din[3]=0xA5, others 0x00. During a unit-3 write, host_buff_din=0xA5 every cycle.
- Reset mid-XFER: pull RESET_N low while host_ack=1. All outputs 0 asynchronously, and no drv_ack during reset.
- Timeout (macro on, TIMEOUT_CYCLES=16): drv_wr[0]=1 with no host_ack. host_wr falls after 16 cycles in REQ, timeout_err=1, and drv_ack stays 0.

Source files
------------

// File: rtl/fdc_sd_pkg.sv
// Shared types for the floppy-controller SD block arbiter.
package fdc_sd_pkg;

    localparam int unsigned MAX_DRIVES = 4;

    typedef logic [1:0] drive_idx_t;

    typedef enum logic [1:0] {IDLE, REQ, XFER, REL} arb_state_t;

endpackage

// File: rtl/fdc_rr_pick.sv
// Combinational round-robin picker: the search starts one past last_grant and wraps.
module fdc_rr_pick
    import fdc_sd_pkg::*;
#(
    parameter int unsigned NUM_DRIVES = 4
) (
    input  logic [NUM_DRIVES-1:0] req,
    input  drive_idx_t            last_grant,
    output logic                  valid,
    output drive_idx_t            winner
);

    logic [MAX_DRIVES-1:0] req_pad;
    drive_idx_t            cand;

    // Walk from the lowest priority up so that the nearest requester overwrites the rest.
    always_comb begin
        req_pad = MAX_DRIVES'(req);
        valid   = 1'b0;
        winner  = '0;
        cand    = '0;
        for (int k = NUM_DRIVES; k >= 1; k--) begin
            cand = drive_idx_t'((32'(last_grant) + 32'(k)) % NUM_DRIVES);
            if (req_pad[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/fdc_sd_arbiter.sv
// Serialises per-drive SD block requests onto one host block channel.
// Optional FDC_SD_ARB_TIMEOUT_EN aborts a grant that sees no host_ack in time.
module fdc_sd_arbiter
    import fdc_sd_pkg::*;
#(
    parameter int unsigned NUM_DRIVES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 33554432
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [NUM_DRIVES-1:0][31:0] drv_lba,
    input  logic [NUM_DRIVES-1:0]       drv_rd,
    input  logic [NUM_DRIVES-1:0]       drv_wr,
    output logic [NUM_DRIVES-1:0]       drv_ack,
    input  logic [NUM_DRIVES-1:0][7:0]  drv_buff_din,
    output logic [31:0]                 host_lba,
    output logic [1:0]                  host_unit,
    output logic                        host_rd,
    output logic                        host_wr,
    input  logic                        host_ack,
    output logic [7:0]                  host_buff_din,
    output logic                        busy,
    output logic                        timeout_err
);

    if (NUM_DRIVES < 2 || NUM_DRIVES > MAX_DRIVES || TIMEOUT_CYCLES < 2) begin : gen_bad_param
        $error("fdc_sd_arbiter: NUM_DRIVES must be 2..4 and TIMEOUT_CYCLES at least 2");
    end

    arb_state_t            state;
    drive_idx_t            last_grant;
    logic [NUM_DRIVES-1:0] rd_q;
    logic [NUM_DRIVES-1:0] wr_q;
    logic                  pick_valid;
    drive_idx_t            pick_winner;
    logic [31:0]           sel_lba;
    logic                  sel_wr;
    logic                  ack_window;

    fdc_rr_pick #(
        .NUM_DRIVES (NUM_DRIVES)
    ) u_pick (
        .req        (rd_q | wr_q),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // Write wins over read on the same drive so a dirty buffer is flushed first.
    always_comb begin
        sel_lba = '0;
        sel_wr  = 1'b0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (pick_winner == drive_idx_t'(i)) begin
                sel_lba = drv_lba[i];
                sel_wr  = wr_q[i];
            end
        end
    end

    assign ack_window = (state == REQ) || (state == XFER);

    always_comb begin
        drv_ack       = '0;
        host_buff_din = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (host_unit == drive_idx_t'(i)) begin
                drv_ack[i]    = ack_window & host_ack;
                host_buff_din = drv_buff_din[i];
            end
        end
    end

`ifdef FDC_SD_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CntW-1:0] tmo_cnt;
    logic            tmo_hit;
    logic            tmo_err_q;

    assign tmo_hit     = (tmo_cnt == CntW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            last_grant <= drive_idx_t'(NUM_DRIVES - 1);
            rd_q       <= '0;
            wr_q       <= '0;
            host_lba   <= '0;
            host_unit  <= '0;
            host_rd    <= 1'b0;
            host_wr    <= 1'b0;
            busy       <= 1'b0;
`ifdef FDC_SD_ARB_TIMEOUT_EN
            tmo_cnt    <= '0;
            tmo_err_q  <= 1'b0;
`endif
        end else begin
            rd_q <= drv_rd;
            wr_q <= drv_wr;
`ifdef FDC_SD_ARB_TIMEOUT_EN
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        host_unit  <= pick_winner;
                        host_lba   <= sel_lba;
                        host_wr    <= sel_wr;
                        host_rd    <= ~sel_wr;
                        last_grant <= pick_winner;
                        busy       <= 1'b1;
                        state      <= REQ;
`ifdef FDC_SD_ARB_TIMEOUT_EN
                        tmo_cnt    <= '0;
`endif
                    end
                end
                REQ: begin
                    if (host_ack) begin
                        host_rd <= 1'b0;
                        host_wr <= 1'b0;
                        state   <= XFER;
`ifdef FDC_SD_ARB_TIMEOUT_EN
                        tmo_cnt <= '0;
                    end else if (tmo_hit) begin
                        host_rd   <= 1'b0;
                        host_wr   <= 1'b0;
                        tmo_err_q <= 1'b1;
                        state     <= REL;
`endif
                    end
                end
                XFER: begin
                    if (!host_ack) begin
                        state <= REL;
`ifdef FDC_SD_ARB_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        tmo_err_q <= 1'b1;
                        state     <= REL;
`endif
                    end
                end
                REL: begin
                    // One quiet cycle lets the drive drop its level request before re-arbitration.
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdc_sd_arbiter.sv
// Self-checking bench for fdc_sd_arbiter; build with FDC_SD_ARB_TIMEOUT_EN for the abort path.
module tb_fdc_sd_arbiter;

`ifdef FDC_SD_ARB_TIMEOUT_EN
    localparam int unsigned TMO      = 16;
    localparam int          READ_LEN = 8;
`else
    localparam int unsigned TMO      = 33554432;
    localparam int          READ_LEN = 512;
`endif

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic [3:0][31:0] drv_lba = '0;
    logic [3:0]       drv_rd = '0;
    logic [3:0]       drv_wr = '0;
    logic [3:0]       drv_ack;
    logic [3:0][7:0]  drv_buff_din = '0;
    logic [31:0]      host_lba;
    logic [1:0]       host_unit;
    logic             host_rd;
    logic             host_wr;
    logic             host_ack = 1'b0;
    logic [7:0]       host_buff_din;
    logic             busy;
    logic             timeout_err;

    int checks = 0;
    int errors = 0;
    int model_last = 3;

    fdc_sd_arbiter #(
        .NUM_DRIVES     (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .drv_lba       (drv_lba),
        .drv_rd        (drv_rd),
        .drv_wr        (drv_wr),
        .drv_ack       (drv_ack),
        .drv_buff_din  (drv_buff_din),
        .host_lba      (host_lba),
        .host_unit     (host_unit),
        .host_rd       (host_rd),
        .host_wr       (host_wr),
        .host_ack      (host_ack),
        .host_buff_din (host_buff_din),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference arbitration: nearest requester after the previous grant, wrapping over 4 drives.
    function automatic int rr_expect(input logic [3:0] pend, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (pend[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RESET_N  = 1'b0;
        drv_rd   = '0;
        drv_wr   = '0;
        host_ack = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N    = 1'b1;
        model_last = 3;
    endtask

    task automatic wait_req(output bit ok, input int max_cycles);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge CLK);
            if (host_rd || host_wr) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Host side of one transfer; the served drive drops its pending bit (write first) on ack.
    task automatic host_xfer(input int len, input int unit);
        host_ack = 1'b1;
        @(negedge CLK);
        if (drv_wr[unit]) drv_wr[unit] = 1'b0;
        else drv_rd[unit] = 1'b0;
        repeat (len - 1) @(negedge CLK);
        host_ack = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({host_rd, host_wr, drv_ack, busy, timeout_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {host_rd, host_wr, drv_ack, busy, timeout_err});
        end
        checks++;
        if ({host_lba, host_unit} !== 34'h0) begin
            errors++;
            $display("FAIL reset_addr: got lba %h unit %0d want 0/0", host_lba, host_unit);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        bit ok;
        int bad = 0;
        do_reset();
        drv_lba[1] = 32'h123;
        drv_rd[1]  = 1'b1;
        @(negedge CLK);
        checks++;
        if (host_rd !== 1'b0) begin
            errors++;
            $display("FAIL read_latency_early: host_rd got %b want 0", host_rd);
        end
        @(negedge CLK);
        checks++;
        if ({host_rd, host_wr, host_unit, host_lba, busy} !== {1'b1, 1'b0, 2'd1, 32'h123, 1'b1}) begin
            errors++;
            $display("FAIL read_grant: rd %b wr %b unit %0d lba %h busy %b want 1 0 1 123 1",
                     host_rd, host_wr, host_unit, host_lba, busy);
        end
        host_ack = 1'b1;
        for (int c = 0; c < READ_LEN; c++) begin
            @(negedge CLK);
            if (c == 0) drv_rd[1] = 1'b0;
            if (drv_ack !== 4'b0010 || host_rd !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL read_ack_window: %0d bad cycles want 0", bad);
        end
        host_ack = 1'b0;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b1 || drv_ack !== 4'b0000) begin
            errors++;
            $display("FAIL read_rel: busy %b ack %b want 1 0000", busy, drv_ack);
        end
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: busy got %b want 0", busy);
        end
        ok = 1'b1;
    endtask

    task automatic test_contention();
        bit ok;
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) drv_lba[i] = $urandom;
        drv_rd = 4'hF;
        for (int t = 0; t < 5; t++) begin
            wait_req(ok, 12);
            checks++;
            if (!ok || host_unit !== 2'(order[t]) || host_lba !== drv_lba[order[t]] || !host_rd) begin
                errors++;
                $display("FAIL contention_%0d: ok %b unit %0d lba %h want unit %0d lba %h",
                         t, ok, host_unit, host_lba, order[t], drv_lba[order[t]]);
            end
            if (t == 2) drv_rd[0] = 1'b1;
            host_xfer(3, order[t]);
        end
    endtask

    task automatic test_rd_wr_same();
        bit ok;
        do_reset();
        drv_lba[2] = 32'hCAFE_0002;
        drv_rd[2]  = 1'b1;
        drv_wr[2]  = 1'b1;
        wait_req(ok, 6);
        checks++;
        if (!ok || {host_wr, host_rd, host_unit} !== {1'b1, 1'b0, 2'd2}) begin
            errors++;
            $display("FAIL rdwr_first: wr %b rd %b unit %0d want 1 0 2", host_wr, host_rd, host_unit);
        end
        host_xfer(2, 2);
        wait_req(ok, 6);
        checks++;
        if (!ok || {host_wr, host_rd, host_unit} !== {1'b0, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL rdwr_second: wr %b rd %b unit %0d want 0 1 2", host_wr, host_rd, host_unit);
        end
        host_xfer(2, 2);
    endtask

    task automatic test_buff_steer();
        bit ok;
        int bad = 0;
        do_reset();
        drv_buff_din = '0;
        drv_buff_din[3] = 8'hA5;
        drv_wr[3] = 1'b1;
        wait_req(ok, 6);
        checks++;
        if (!ok || host_unit !== 2'd3 || !host_wr) begin
            errors++;
            $display("FAIL steer_grant: unit %0d wr %b want 3 1", host_unit, host_wr);
        end
        host_ack = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (c == 0) drv_wr[3] = 1'b0;
            if (host_buff_din !== 8'hA5) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL steer_data: %0d bad cycles want 0", bad);
        end
        host_ack = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_spurious_ack();
        int bad = 0;
        do_reset();
        host_ack = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            if (drv_ack !== 4'b0000 || busy !== 1'b0) bad++;
        end
        host_ack = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL spurious_ack: %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_reset_mid_xfer();
        bit ok;
        do_reset();
        drv_lba[0] = 32'h55;
        drv_rd[0]  = 1'b1;
        wait_req(ok, 6);
        host_ack = 1'b1;
        @(negedge CLK);
        checks++;
        if (!ok || drv_ack !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_pre: ack %b want 0001", drv_ack);
        end
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({host_rd, host_wr, drv_ack, busy, host_lba, host_unit} !== 41'h0) begin
            errors++;
            $display("FAIL midrst_async: rd %b wr %b ack %b busy %b lba %h unit %0d want all 0",
                     host_rd, host_wr, drv_ack, busy, host_lba, host_unit);
        end
        @(negedge CLK);
        checks++;
        if (drv_ack !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_hold: ack %b want 0000", drv_ack);
        end
        host_ack = 1'b0;
        RESET_N  = 1'b1;
        model_last = 3;
        wait_req(ok, 6);
        checks++;
        if (!ok || host_unit !== 2'd0 || !host_rd || host_lba !== 32'h55) begin
            errors++;
            $display("FAIL midrst_rereq: unit %0d rd %b lba %h want 0 1 55", host_unit, host_rd, host_lba);
        end
        host_xfer(2, 0);
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        int acks = 0;
        do_reset();
        drv_wr[0] = 1'b1;
        wait_req(ok, 6);
`ifdef FDC_SD_ARB_TIMEOUT_EN
        for (int c = 0; c < 40 && host_wr; c++) begin
            n++;
            if (drv_ack !== 4'b0000) acks++;
            @(negedge CLK);
        end
        drv_wr[0] = 1'b0;
        checks++;
        if (!ok || n != 16 || acks != 0) begin
            errors++;
            $display("FAIL timeout_len: held %0d acks %0d want 16 0", n, acks);
        end
        checks++;
        if (timeout_err !== 1'b1 || drv_ack !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_flag: err %b ack %b want 1 0000", timeout_err, drv_ack);
        end
        repeat (20) @(negedge CLK);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: err %b want 1", timeout_err);
        end
        do_reset();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: err %b want 0", timeout_err);
        end
`else
        for (int c = 0; c < 40; c++) begin
            if (host_wr) n++;
            if (timeout_err !== 1'b0) acks++;
            @(negedge CLK);
        end
        checks++;
        if (!ok || n != 40 || acks != 0) begin
            errors++;
            $display("FAIL no_timeout: held %0d err cycles %0d want 40 0", n, acks);
        end
        host_xfer(2, 0);
`endif
    endtask

    task automatic raise_random(input bit force_one);
        int r;
        for (int i = 0; i < 4; i++) begin
            if (!drv_rd[i] && !drv_wr[i] && $urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 2);
                drv_lba[i] = $urandom;
                drv_rd[i]  = (r != 1);
                drv_wr[i]  = (r != 0);
            end
        end
        if (force_one && (drv_rd | drv_wr) == 4'b0000) begin
            r = $urandom_range(0, 3);
            drv_lba[r] = $urandom;
            drv_rd[r]  = 1'b1;
        end
    endtask

    task automatic test_random();
        bit ok;
        int exp_unit;
        bit exp_wr;
        logic [31:0] exp_lba;
        int d;
        int len;
        int bad;
        do_reset();
        for (int t = 0; t < 40; t++) begin
            if ((drv_rd | drv_wr) == 4'b0000) raise_random(1'b1);
            exp_unit = rr_expect(drv_rd | drv_wr, model_last);
            exp_wr   = drv_wr[exp_unit];
            exp_lba  = drv_lba[exp_unit];
            wait_req(ok, 10);
            checks++;
            if (!ok || host_unit !== 2'(exp_unit) || host_wr !== exp_wr || host_rd !== !exp_wr
                || host_lba !== exp_lba) begin
                errors++;
                $display("FAIL rand_grant_%0d: unit %0d wr %b rd %b lba %h want %0d %b %b %h",
                         t, host_unit, host_wr, host_rd, host_lba, exp_unit, exp_wr, !exp_wr, exp_lba);
            end
            model_last = exp_unit;
            raise_random(1'b0);
            drv_lba[exp_unit] = $urandom;
            d   = $urandom_range(0, 3);
            bad = 0;
            for (int c = 0; c < d; c++) begin
                @(negedge CLK);
                if (host_lba !== exp_lba || !(host_rd || host_wr) || drv_ack !== 4'b0000) bad++;
            end
            host_ack = 1'b1;
            len = $urandom_range(1, 6);
            for (int c = 0; c < len; c++) begin
                @(negedge CLK);
                if (c == 0) begin
                    if (drv_wr[exp_unit]) drv_wr[exp_unit] = 1'b0;
                    else drv_rd[exp_unit] = 1'b0;
                end
                for (int i = 0; i < 4; i++) drv_buff_din[i] = 8'($urandom);
                #1;
                if (drv_ack !== 4'(1 << exp_unit) || host_buff_din !== drv_buff_din[exp_unit]
                    || host_rd || host_wr) bad++;
            end
            host_ack = 1'b0;
            @(negedge CLK);
            if (busy !== 1'b1 || drv_ack !== 4'b0000) bad++;
            @(negedge CLK);
            if (busy !== 1'b0) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand_xfer_%0d: %0d bad cycles want 0", t, bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_rd_wr_same();
        test_buff_steer();
        test_spurious_ack();
        test_reset_mid_xfer();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
